// File: rtl/signal_controller.sv
// signal_controller: sequences one approach cycle around the subtractor stage.
// Arms the subtractor, follows the countdown, issues a brake request when the
// vehicle reaches the stop line before the countdown expires, then holds green
// for GREEN_SECS seconds before returning to idle.
//
// Handshake: there is no valid/ready pair here. start, abort, valid_data and
// seconds_tick are single-cycle strobes sampled on the rising clock edge.
// The FSM only reacts to a strobe in the state that expects it. Every output
// is a register that updates on the edge after the causing input is sampled.
module signal_controller #(
   parameter int AMBER_SECS = 3,
   parameter int GREEN_SECS = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       valid_data,
   input  logic       seconds_tick,
   input  logic       signal_switch,
   input  logic       signal_reached,
   input  logic [5:0] remaining,
   output logic       sub_enable,
   output logic       light_red,
   output logic       light_amber,
   output logic       light_green,
   output logic       brake,
   output logic       cycle_done,
   output logic [7:0] stop_count,
   output logic [2:0] state_dbg
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_STOP = 3'd3;
   localparam logic [2:0] S_GO   = 3'd4;

   localparam logic [5:0] AMBER_LIM  = 6'(AMBER_SECS);
   localparam logic [5:0] GREEN_LAST = 6'(GREEN_SECS - 1);

   logic [2:0] state;
   logic [2:0] state_nx;
   logic [5:0] green_cnt;
   logic       green_done;
   logic       amber_nx;
   logic       green_nx;
   logic       stop_inc;

   assign state_dbg = state;

   // Next-state decode; abort wins over everything else
   always_comb begin
      state_nx   = state;
      green_done = (state == S_GO) && seconds_tick && (green_cnt == GREEN_LAST);
      case (state)
         S_IDLE: if (start) state_nx = S_LOAD;
         S_LOAD: if (valid_data) state_nx = S_RUN;
         // signal_switch is stale (1) until the subtractor is loaded, so it
         // is only looked at in RUN and STOP; expiry beats reached.
         S_RUN: begin
            if (signal_switch)       state_nx = S_GO;
            else if (signal_reached) state_nx = S_STOP;
         end
         S_STOP: if (signal_switch) state_nx = S_GO;
         S_GO:   if (green_done) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (abort) state_nx = S_IDLE;
   end

   // Lamp decision for the next cycle; amber uses the live remaining count
   always_comb begin
      green_nx = (state_nx == S_GO);
      amber_nx = (state_nx == S_RUN) && (remaining != 6'd0) && (remaining <= AMBER_LIM);
      stop_inc = (state == S_RUN) && (state_nx == S_STOP);
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Green timer: restarts on GO entry, counts ticks only while in GO
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         green_cnt <= 6'd0;
      end else if (abort || ((state_nx == S_GO) && (state != S_GO))) begin
         green_cnt <= 6'd0;
      end else if ((state == S_GO) && seconds_tick) begin
         green_cnt <= green_cnt + 6'd1;
      end
   end

   // Registered outputs decoded from the next state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sub_enable  <= 1'b0;
         light_red   <= 1'b1;
         light_amber <= 1'b0;
         light_green <= 1'b0;
         brake       <= 1'b0;
         cycle_done  <= 1'b0;
      end else begin
         sub_enable  <= (state_nx == S_LOAD) || (state_nx == S_RUN) || (state_nx == S_STOP);
         light_red   <= !green_nx && !amber_nx;
         light_amber <= amber_nx;
         light_green <= green_nx;
         brake       <= (state_nx == S_STOP);
         cycle_done  <= green_done && !abort;
      end
   end

   // Forced-stop counter; saturates, survives abort, cleared only by reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stop_count <= 8'd0;
      end else if (stop_inc && (stop_count != 8'hFF)) begin
         stop_count <= stop_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_signal_controller.sv
// tb_signal_controller: scenario tasks around signal_controller with a small
// behavioural subtractor driving remaining/signal_switch. A scoreboard queue
// holds the expected sequence of output-vector changes.
module tb_signal_controller;

   localparam int AMBER_SECS = 3;
   localparam int GREEN_SECS = 5;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_STOP = 3'd3;
   localparam logic [2:0] S_GO   = 3'd4;

   // {sub_enable, red, amber, green, brake}
   localparam logic [4:0] V_IDLE  = 5'b01000;
   localparam logic [4:0] V_LOAD  = 5'b11000;
   localparam logic [4:0] V_AMBER = 5'b10100;
   localparam logic [4:0] V_STOP  = 5'b11001;
   localparam logic [4:0] V_GO    = 5'b00010;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       valid_data = 1'b0;
   logic       seconds_tick = 1'b0;
   logic       signal_switch;
   logic       signal_reached;
   logic [5:0] remaining;
   logic       sub_enable, light_red, light_amber, light_green, brake, cycle_done;
   logic [7:0] stop_count;
   logic [2:0] state_dbg;

   int checks = 0;
   int failures = 0;
   logic [4:0] exp_q[$];
   logic [4:0] prev_vec = V_IDLE;
   int done_pulses = 0;
   int green_ticks = 0;
   int brake_cycles = 0;
   int tick_phase = 0;
   logic tick_en = 1'b0;
   int exp_stops = 0;

   logic [5:0] sub_cnt;
   logic [5:0] load_val = 6'd0;
   logic       reached_drv = 1'b0;
   logic       reach_on_zero = 1'b0;

   signal_controller #(.AMBER_SECS(AMBER_SECS), .GREEN_SECS(GREEN_SECS)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .valid_data     (valid_data),
      .seconds_tick   (seconds_tick),
      .signal_switch  (signal_switch),
      .signal_reached (signal_reached),
      .remaining      (remaining),
      .sub_enable     (sub_enable),
      .light_red      (light_red),
      .light_amber    (light_amber),
      .light_green    (light_green),
      .brake          (brake),
      .cycle_done     (cycle_done),
      .stop_count     (stop_count),
      .state_dbg      (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   // Behavioural subtractor: loads on valid_data, counts down on ticks
   always @(posedge clock or negedge reset) begin
      if (!reset) sub_cnt <= 6'd0;
      else if (sub_enable && valid_data) sub_cnt <= load_val;
      else if (sub_enable && seconds_tick && sub_cnt != 6'd0) sub_cnt <= sub_cnt - 6'd1;
   end

   assign remaining      = sub_cnt;
   assign signal_switch  = (sub_cnt == 6'd0);
   assign signal_reached = reached_drv | (reach_on_zero & (sub_cnt == 6'd0));

   // ---------------- driver: advance n cycles, pop scoreboard ----------------
   task automatic step(input int n);
      logic [4:0] obs;
      logic [4:0] exp_v;
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
         tick_phase++;
         seconds_tick = tick_en && ((tick_phase % 4) == 0);
         @(negedge clock);
         if (!reset) begin
            prev_vec = V_IDLE;
         end else begin
            obs = {sub_enable, light_red, light_amber, light_green, brake};
            checks++;
            if ($countones({light_red, light_amber, light_green}) != 1) begin
               failures++;
               $display("FAIL lamp_onehot got=%b want=one lamp", {light_red, light_amber, light_green});
            end
            if (obs !== prev_vec) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL sb_unexpected got=%b want=no change from %b", obs, prev_vec);
               end else begin
                  exp_v = exp_q.pop_front();
                  if (obs !== exp_v) begin
                     failures++;
                     $display("FAIL sb_change got=%b want=%b", obs, exp_v);
                  end
               end
               prev_vec = obs;
            end
            if (cycle_done) done_pulses++;
            if (light_green && seconds_tick) green_ticks++;
            if (brake) brake_cycles++;
         end
      end
   endtask

   task automatic go_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic go_load(input logic [5:0] v);
      valid_data = 1'b1;
      load_val = v;
      step(1);
      valid_data = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b0;
      step(3);
      checks++;
      if ({sub_enable, light_red, light_amber, light_green, brake, cycle_done} !== 6'b010000 || stop_count !== 8'd0) begin
         failures++;
         $display("FAIL reset_hold got=%b/%0d want=010000/0",
                  {sub_enable, light_red, light_amber, light_green, brake, cycle_done}, stop_count);
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         checks++;
         if ({sub_enable, light_red, light_amber, light_green, brake} !== V_IDLE || stop_count !== 8'd0 || state_dbg !== S_IDLE) begin
            failures++;
            $display("FAIL reset_release got=%b/%0d/%0d want=%b/0/0",
                     {sub_enable, light_red, light_amber, light_green, brake}, stop_count, state_dbg, V_IDLE);
         end
      end
   endtask

   task automatic test_normal_cycle();
      int n;
      int d0;
      exp_q.push_back(V_LOAD);
      exp_q.push_back(V_AMBER);
      exp_q.push_back(V_GO);
      exp_q.push_back(V_IDLE);
      tick_en = 1'b1;
      go_start();
      checks++;
      if (sub_enable !== 1'b1 || state_dbg !== S_LOAD) begin
         failures++;
         $display("FAIL sub_enable_rise got=%b/%0d want=1/%0d", sub_enable, state_dbg, S_LOAD);
      end
      go_load(6'd10);
      checks++;
      if (state_dbg !== S_RUN || remaining !== 6'd10 || light_red !== 1'b1) begin
         failures++;
         $display("FAIL normal_run_entry got=%0d/%0d/%b want=%0d/10/1", state_dbg, remaining, light_red, S_RUN);
      end
      d0 = done_pulses;
      green_ticks = 0;
      n = 0;
      while (state_dbg !== S_IDLE && n < 300) begin
         step(1);
         n++;
      end
      checks++;
      if (state_dbg !== S_IDLE) begin
         failures++;
         $display("FAIL normal_timeout got=%0d want=%0d", state_dbg, S_IDLE);
      end
      step(2);
      checks++;
      if (done_pulses - d0 != 1) begin
         failures++;
         $display("FAIL normal_cycle_done got=%0d want=1", done_pulses - d0);
      end
      checks++;
      if (green_ticks != GREEN_SECS) begin
         failures++;
         $display("FAIL green_ticks got=%0d want=%0d", green_ticks, GREEN_SECS);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL normal_sb_left got=%0d want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_forced_stop();
      int n;
      int d0;
      exp_q.push_back(V_LOAD);
      exp_q.push_back(V_STOP);
      exp_q.push_back(V_GO);
      exp_q.push_back(V_IDLE);
      d0 = done_pulses;
      go_start();
      go_load(6'd8);
      n = 0;
      while (remaining !== 6'd4 && n < 100) begin
         step(1);
         n++;
      end
      checks++;
      if (remaining !== 6'd4) begin
         failures++;
         $display("FAIL stop_wait4 got=%0d want=4", remaining);
      end
      reached_drv = 1'b1;
      step(1);
      exp_stops++;
      checks++;
      if (brake !== 1'b1 || state_dbg !== S_STOP || stop_count !== 8'(exp_stops)) begin
         failures++;
         $display("FAIL stop_entry got=%b/%0d/%0d want=1/%0d/%0d", brake, state_dbg, stop_count, S_STOP, exp_stops);
      end
      n = 0;
      while (state_dbg !== S_IDLE && n < 300) begin
         step(1);
         n++;
      end
      reached_drv = 1'b0;
      step(2);
      checks++;
      if (state_dbg !== S_IDLE || brake !== 1'b0 || done_pulses - d0 != 1) begin
         failures++;
         $display("FAIL stop_finish got=%0d/%b/%0d want=%0d/0/1", state_dbg, brake, done_pulses - d0, S_IDLE);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL stop_sb_left got=%0d want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reach_with_switch();
      int n;
      exp_q.push_back(V_LOAD);
      exp_q.push_back(V_AMBER);
      exp_q.push_back(V_GO);
      exp_q.push_back(V_IDLE);
      reach_on_zero = 1'b1;
      brake_cycles = 0;
      go_start();
      go_load(6'd2);
      n = 0;
      while (state_dbg !== S_IDLE && n < 300) begin
         step(1);
         n++;
      end
      step(2);
      reach_on_zero = 1'b0;
      checks++;
      if (state_dbg !== S_IDLE || stop_count !== 8'(exp_stops) || brake_cycles != 0) begin
         failures++;
         $display("FAIL reach_switch got=%0d/%0d/%0d want=%0d/%0d/0", state_dbg, stop_count, brake_cycles, S_IDLE, exp_stops);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL reach_sb_left got=%0d want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_zero_load();
      int n;
      exp_q.push_back(V_LOAD);
      exp_q.push_back(V_GO);
      exp_q.push_back(V_IDLE);
      go_start();
      for (int i = 0; i < 3; i++) begin
         step(1);
         checks++;
         if (state_dbg !== S_LOAD || signal_switch !== 1'b1) begin
            failures++;
            $display("FAIL zero_hold_load got=%0d/%b want=%0d/1", state_dbg, signal_switch, S_LOAD);
         end
      end
      go_load(6'd0);
      checks++;
      if (state_dbg !== S_RUN || light_red !== 1'b1) begin
         failures++;
         $display("FAIL zero_run got=%0d/%b want=%0d/1", state_dbg, light_red, S_RUN);
      end
      step(1);
      checks++;
      if (state_dbg !== S_GO || light_green !== 1'b1) begin
         failures++;
         $display("FAIL zero_go got=%0d/%b want=%0d/1", state_dbg, light_green, S_GO);
      end
      n = 0;
      while (state_dbg !== S_IDLE && n < 300) begin
         step(1);
         n++;
      end
      step(2);
      checks++;
      if (exp_q.size() != 0 || state_dbg !== S_IDLE) begin
         failures++;
         $display("FAIL zero_sb_left got=%0d/%0d want=0/%0d", exp_q.size(), state_dbg, S_IDLE);
         exp_q.delete();
      end
   endtask

   task automatic test_abort();
      int d0;
      exp_q.push_back(V_LOAD);
      exp_q.push_back(V_STOP);
      exp_q.push_back(V_IDLE);
      d0 = done_pulses;
      go_start();
      go_load(6'd8);
      reached_drv = 1'b1;
      step(1);
      reached_drv = 1'b0;
      exp_stops++;
      checks++;
      if (state_dbg !== S_STOP) begin
         failures++;
         $display("FAIL abort_pre got=%0d want=%0d", state_dbg, S_STOP);
      end
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      checks++;
      if (state_dbg !== S_IDLE || brake !== 1'b0 || sub_enable !== 1'b0 || cycle_done !== 1'b0 || done_pulses != d0) begin
         failures++;
         $display("FAIL abort_stop got=%0d/%b/%b/%b want=%0d/0/0/0", state_dbg, brake, sub_enable, cycle_done, S_IDLE);
      end
      checks++;
      if (stop_count !== 8'(exp_stops)) begin
         failures++;
         $display("FAIL abort_keeps_count got=%0d want=%0d", stop_count, exp_stops);
      end
      abort = 1'b1;
      start = 1'b1;
      step(1);
      abort = 1'b0;
      start = 1'b0;
      step(1);
      checks++;
      if (state_dbg !== S_IDLE || sub_enable !== 1'b0) begin
         failures++;
         $display("FAIL abort_with_start got=%0d/%b want=%0d/0", state_dbg, sub_enable, S_IDLE);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL abort_sb_left got=%0d want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_stop_saturation();
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back(V_LOAD);
         exp_q.push_back(V_STOP);
         exp_q.push_back(V_IDLE);
         go_start();
         go_load(6'(8 + $urandom_range(0, 20)));
         reached_drv = 1'b1;
         step(1);
         reached_drv = 1'b0;
         abort = 1'b1;
         step(1);
         abort = 1'b0;
         if (exp_stops < 255) exp_stops++;
         checks++;
         if (stop_count !== 8'(exp_stops)) begin
            failures++;
            $display("FAIL sat_count iter=%0d got=%0d want=%0d", i, stop_count, exp_stops);
         end
      end
      checks++;
      if (stop_count !== 8'd255) begin
         failures++;
         $display("FAIL sat_final got=%0d want=255", stop_count);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sat_sb_left got=%0d want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_async_reset();
      exp_q.push_back(V_LOAD);
      go_start();
      go_load(6'd10);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({sub_enable, light_red, light_amber, light_green, brake, cycle_done} !== 6'b010000 ||
          stop_count !== 8'd0 || state_dbg !== S_IDLE) begin
         failures++;
         $display("FAIL async_reset got=%b/%0d/%0d want=010000/0/%0d",
                  {sub_enable, light_red, light_amber, light_green, brake, cycle_done}, stop_count, state_dbg, S_IDLE);
      end
      exp_stops = 0;
      step(2);
      reset = 1'b1;
      step(2);
      checks++;
      if (state_dbg !== S_IDLE || {sub_enable, light_red, light_amber, light_green, brake} !== V_IDLE || exp_q.size() != 0) begin
         failures++;
         $display("FAIL async_release got=%0d/%b/%0d want=%0d/%b/0",
                  state_dbg, {sub_enable, light_red, light_amber, light_green, brake}, exp_q.size(), S_IDLE, V_IDLE);
         exp_q.delete();
      end
   endtask

   // ---------------- sequence + final report ----------------
   initial begin
      test_reset();
      test_normal_cycle();
      test_forced_stop();
      test_reach_with_switch();
      test_zero_load();
      test_abort();
      test_stop_saturation();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/signal_controller.md
# signal_controller

Downstream consumer of the subtractor stage. Watches the countdown-expired flag (`signal_switch`), the distance-reached flag (`signal_reached`) and the remaining-seconds count. It drives the signal lamps and the vehicle brake request, and gates the subtractor through `sub_enable`. One FSM per approach cycle: arm, count down, stop if needed, show green, then return to idle.

## Interface
- `AMBER_SECS`, 3: amber is lit while 0 < `remaining` <= AMBER_SECS during countdown.
- `GREEN_SECS`, 5: number of `seconds_tick` pulses green is held; legal range 1..63.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new approach cycle; honoured only in IDLE.
- `abort`  in  1  return to IDLE from any state.
- `valid_data`  in  1  same strobe that loads the subtractor; marks load of a countdown.
- `seconds_tick`  in  1  one-cycle pulse per second.
- `signal_switch`  in  1  subtractor countdown == 0.
- `signal_reached`  in  1  subtractor remaining distance <= speed.
- `remaining`  in  6  subtractor seconds count (`data_out1`).
- `sub_enable`  out  1  enables the subtractor.
- `light_red`, `light_amber`, `light_green`  out  1 each  lamp drives; exactly one is high at all times.
- `brake`  out  1  stop request to vehicle.
- `cycle_done`  out  1  one-cycle pulse when an approach cycle completes.
- `stop_count`  out  8  number of forced stops; saturates at 255.

## Operation
- States:
  - IDLE: `sub_enable`=0, red.
  - LOAD: `sub_enable`=1, red, waiting for `valid_data`.
  - RUN: `sub_enable`=1, countdown running.
  - STOP: `sub_enable`=1, red, `brake`=1.
  - GO: `sub_enable`=0, green, green timer running.
- Transitions:
  - IDLE→LOAD on `start`.
  - LOAD→RUN on `valid_data`.
  - RUN→GO on `signal_switch`.
  - RUN→STOP on `signal_reached` && !`signal_switch`.
  - STOP→GO on `signal_switch`.
  - GO→IDLE on the `seconds_tick` that brings the green counter to GREEN_SECS. `cycle_done` pulses in that same cycle.
- `abort` overrides all other transitions: next state IDLE, green counter cleared, no `cycle_done`.
- `signal_switch` is ignored in IDLE and LOAD, because it is 1 after subtractor reset. It is sampled only in RUN and STOP.
- RUN priority: `signal_switch` beats `signal_reached`; both high → GO, no stop counted.
- Lamps in RUN: amber if `remaining` is nonzero and <= AMBER_SECS, otherwise red. Green only in GO.
- `brake` = 1 only in STOP.
- `stop_count` increments on each RUN→STOP transition and saturates at 255. Only reset clears it; `abort` does not.
- Green counter: 6-bit. Cleared on entry to GO; increments on `seconds_tick` in GO only.
- `start` outside IDLE and `valid_data` outside LOAD are ignored by the FSM.

## Timing
- All outputs are registered and change on the clock edge after the causing input is sampled.
- Reset values:
  - state IDLE;
  - `sub_enable`=0, `light_red`=1, `light_amber`=0, `light_green`=0;
  - `brake`=0, `cycle_done`=0;
  - `stop_count`=0, green counter=0.
- `sub_enable` rises 1 cycle after `start`. It is already high on the cycle `valid_data` arrives, so the subtractor loads on that edge.
- LOAD→RUN takes effect 1 cycle after `valid_data`, when the subtractor count is valid. A load value of 0 gives RUN→GO on the first RUN cycle.
- `remaining` is combinationally mapped to the next-state amber/red decision. The lamp registers update 1 cycle later.
- Green lasts exactly GREEN_SECS ticks. A tick in the GO-entry cycle is not counted.
- Asserting `reset` mid-cycle forces the reset values immediately (asynchronously). Release is synchronised by the clock edge.
- `abort` and `start` in the same IDLE cycle: stay in IDLE.

## Test plan
- Reset with `reset`=0, then release → red=1, `sub_enable`=0, `stop_count`=0, `brake`=0 until `start`.
- `start`, then `valid_data` loading 10 with no `signal_reached`, ticks every 4 cycles → red while `remaining`>3, amber at 3..1, green at 0. Green held for 5 ticks, one `cycle_done` pulse, return to IDLE.
- `signal_reached` asserted with `remaining`=4 → STOP, `brake`=1, `stop_count`=1. Countdown to 0 → `brake`=0, green.
- `signal_reached` and `signal_switch` rising in the same cycle → GO directly, `stop_count` unchanged, `brake` never high.
- `valid_data` loading 0 → GO on the first RUN cycle. `signal_switch` held high through IDLE and LOAD causes no early exit.
- `abort` during STOP → IDLE next cycle, `brake`=0, `sub_enable`=0, no `cycle_done`. 256 forced stops → `stop_count`=255 and holds.
